// File: rtl/game_pkg.sv
//==============================================================================
// game_pkg : shared types and widths for the Stop-It round sequencer
// Revision : 1.0
//==============================================================================
`default_nettype none

package game_pkg;

    localparam int COUNT_W    = 5;
    localparam int SCORE_W    = 4;
    localparam int LEVEL_W    = 2;
    localparam int MAX_LEVEL  = 3;
    localparam int MAX_TARGET = 30;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } game_state_e;

endpackage : game_pkg

`default_nettype wire

// File: rtl/game_lfsr.sv
//==============================================================================
// game_lfsr : 5-bit Fibonacci LFSR (x^5 + x^3 + 1) used to draw round targets
// Revision  : 1.0
//==============================================================================
`default_nettype none

module game_lfsr
    import game_pkg::*;
#(
    parameter logic [COUNT_W-1:0] SEED = 5'h15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic [COUNT_W-1:0] value_o
);

    logic [COUNT_W-1:0] value_q;
    logic [COUNT_W-1:0] value_d;

    // Maximal-length: a nonzero seed visits every value 1..31
    assign value_d = {value_q[3:0], value_q[4] ^ value_q[2]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= SEED;
        end else if (en_i) begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule : game_lfsr

`default_nettype wire

// File: rtl/game_controller.sv
//==============================================================================
// game_controller : Stop-It round sequencer - arms/freezes the down-counter,
//                   judges the stop press, tracks score and level
// Revision        : 1.0
//==============================================================================
`default_nettype none

module game_controller
    import game_pkg::*;
#(
    parameter int                 RESULT_CYCLES = 8,
    parameter int                 TOLERANCE     = 0,
    parameter logic [COUNT_W-1:0] LFSR_SEED     = 5'h15
) (
    input  logic               clk_4_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic               counter_en_o,
    output logic               counter_rst_no,
    output logic [COUNT_W-1:0] target_o,
    output logic               win_o,
    output logic               lose_o,
    output logic               blink_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int                HOLD_W    = $clog2(RESULT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_CYCLES - 1);

    game_state_e        state_q, state_d;
    logic [1:0]         presc_q, presc_d;
    logic               en_q, en_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               blink_q, blink_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic               start_q, stop_q, arm_q;

    logic               start_rise, stop_rise, count_zero, in_tolerance;
    logic [1:0]         presc_limit;
    logic [COUNT_W-1:0] lfsr_value;
    logic [COUNT_W:0]   cnt_ext, tgt_ext, diff;

    game_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_4_i),
        .rst_ni  (rst_ni),
        .en_i    (1'b1),
        .value_o (lfsr_value)
    );

    // A start button held through reset must be released before it can start a round
    assign start_rise  = start_i & ~start_q & arm_q;
    assign stop_rise   = stop_i & ~stop_q;
    assign count_zero  = (count_i == '0);
    assign presc_limit = 2'(MAX_LEVEL) - level_q;

    assign cnt_ext      = {1'b0, count_i};
    assign tgt_ext      = {1'b0, target_q};
    assign diff         = (cnt_ext >= tgt_ext) ? (cnt_ext - tgt_ext) : (tgt_ext - cnt_ext);
    assign in_tolerance = (diff <= (COUNT_W + 1)'(TOLERANCE));

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        hold_d   = hold_q;
        blink_d  = 1'b0;
        score_d  = score_q;
        level_d  = level_q;
        target_d = target_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    target_d = (lfsr_value == '1) ? COUNT_W'(MAX_TARGET) : lfsr_value;
                    presc_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop_rise) begin
                    state_d = CHECK;
                end else if (count_zero) begin
                    score_d = '0;
                    level_d = '0;
                    hold_d  = '0;
                    blink_d = 1'b1;
                    state_d = LOSE;
                end else begin
                    presc_d = (presc_q == presc_limit) ? 2'd0 : presc_q + 2'd1;
                end
            end
            CHECK: begin
                hold_d  = '0;
                blink_d = 1'b1;
                if (in_tolerance) begin
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    level_d = (level_q == LEVEL_W'(MAX_LEVEL)) ? level_q : level_q + LEVEL_W'(1);
                    state_d = WIN;
                end else begin
                    score_d = '0;
                    level_d = '0;
                    state_d = LOSE;
                end
            end
            WIN, LOSE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                    blink_d = ~blink_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Decide one cycle ahead so the enable leaves a flop
        en_d = (state_d == RUN) && (presc_d == presc_limit);
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            en_q     <= 1'b0;
            hold_q   <= '0;
            blink_q  <= 1'b0;
            score_q  <= '0;
            level_q  <= '0;
            target_q <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            en_q     <= en_d;
            hold_q   <= hold_d;
            blink_q  <= blink_d;
            score_q  <= score_d;
            level_q  <= level_d;
            target_q <= target_d;
            start_q  <= start_i;
            stop_q   <= stop_i;
            arm_q    <= arm_q | ~start_i;
        end
    end

    // Stop and zero gate the enable the same cycle so the count never moves past them
    assign counter_en_o   = en_q & (state_q == RUN) & ~stop_rise & ~count_zero;
    assign counter_rst_no = (state_q != IDLE);
    assign target_o       = target_q;
    assign win_o          = (state_q == WIN);
    assign lose_o         = (state_q == LOSE);
    assign blink_o        = blink_q;
    assign score_o        = score_q;
    assign level_o        = level_q;

endmodule : game_controller

`default_nettype wire
